// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage constants, hold levels and the buffered fetch record.
// No logic; imported by the fetch stage, its FIFO and the bench.
`ifndef INST_FETCH_DEFINES
`define INST_FETCH_DEFINES
`define CpuResetAddr  32'h0000_0000
`define Hold_Flag_Bus 2:0
`define Hold_None     3'b000
`define Hold_Pc       3'b001
`define Hold_If       3'b010
`define Hold_Id       3'b011
`define INST_NOP      32'h0000_0013
`define ZeroWord      32'h0000_0000
`define InstBus       31:0
`define InstAddrBus   31:0
`endif

package inst_fetch_pkg;
  localparam logic [31:0] CPU_RESET_ADDR = `CpuResetAddr;
  localparam logic [2:0]  HOLD_NONE      = `Hold_None;
  localparam logic [2:0]  HOLD_PC        = `Hold_Pc;
  localparam logic [2:0]  HOLD_IF        = `Hold_If;
  localparam logic [2:0]  HOLD_ID        = `Hold_Id;
  localparam logic [31:0] INST_NOP       = `INST_NOP;
  localparam logic [31:0] ZERO_WORD      = `ZeroWord;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_t;
endpackage

// File: rtl/inst_fetch_fifo.sv
// Generic DEPTH-entry sync FIFO with synchronous flush; data visible 1 cycle after push.
// No internal backpressure: the producer must honour full (credit-checked upstream).
module inst_fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + CW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + CW'(1);
    end
  end

  assert property (@(posedge clk) disable iff (!rst) !(push && full && !flush));
endmodule

// File: rtl/inst_fetch.sv
// PC generator / instruction-bus master feeding IF/ID; response word visible 1 cycle after rvalid.
// Credit-limited (outstanding + buffered <= DEPTH); IF/ID hold freezes the presented head.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = CPU_RESET_ADDR,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [2:0]  hold_flag_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  output logic [31:0] pc_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding, discard, out_nxt, buf_count, aq_count;
  logic          hs, credit_ok, drop, push, pop;
  logic          buf_empty, buf_full, aq_empty, aq_full;
  logic [31:0]   aq_head;
  fetch_t        buf_head;

  // In-flight fetches reserve a buffer slot, so a response can never overflow.
  assign credit_ok   = (outstanding + buf_count) < CW'(DEPTH);
  assign ibus_req_o  = rst & ~jump_flag_i & (hold_flag_i < HOLD_PC) & credit_ok;
  assign ibus_addr_o = pc;
  assign pc_o        = pc;
  assign hs          = ibus_req_o & ibus_gnt_i;

  assign drop    = ibus_rvalid_i & (discard != '0);
  assign push    = ibus_rvalid_i & ~drop & ~jump_flag_i;
  assign pop     = inst_valid_o & (hold_flag_i < HOLD_IF) & ~jump_flag_i;
  assign out_nxt = outstanding + CW'(hs) - CW'(ibus_rvalid_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_ADDR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_nxt;
      if (jump_flag_i) begin
        // Everything still on the bus after this cycle belongs to the old stream.
        pc      <= {jump_addr_i[31:2], 2'b00};
        discard <= out_nxt;
      end else begin
        if (hs)   pc      <= pc + 32'd4;
        if (drop) discard <= discard - CW'(1);
      end
    end
  end

  inst_fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_addr_q (
    .clk      (clk),
    .rst      (rst),
    .flush    (jump_flag_i),
    .push     (hs),
    .push_dat (pc),
    .pop      (push),
    .pop_dat  (aq_head),
    .full     (aq_full),
    .empty    (aq_empty),
    .count    (aq_count)
  );

  inst_fetch_fifo #(.W(64), .DEPTH(DEPTH)) u_inst_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (jump_flag_i),
    .push     (push),
    .push_dat ({aq_head, ibus_rdata_i}),
    .pop      (pop),
    .pop_dat  (buf_head),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (buf_count)
  );

  assign inst_valid_o = ~buf_empty;
  assign inst_o       = buf_empty ? INST_NOP  : buf_head.data;
  assign inst_addr_o  = buf_empty ? ZERO_WORD : buf_head.addr;

  logic unused_ok;
  assign unused_ok = ^{jump_addr_i[1:0], buf_full, aq_empty, aq_full, aq_count};
endmodule
